// File: rtl/gridding_sched.sv
// Issues one visibility sample per SSIZE-cycle slot as SSIZE rows; rows of a slot follow its decision edge by one cycle.
// in_ready is combinational and only asserts in the decision cycle; overlapping samples are parked in a small defer buffer.
module gridding_sched #(
    parameter int NSAMPLE     = 1820,
    parameter int GSIZE       = 128,
    parameter int SSIZE       = 15,
    parameter int SUPPORT     = 7,
    parameter int HAZ_SLOTS   = 2,
    parameter int DEFER_DEPTH = 2,
    parameter int DRAIN       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_iu,
    input  logic [31:0] in_iv,
    input  logic [31:0] in_offset,
    input  logic [63:0] in_data,
    output logic        row_valid,
    output logic        row_first,
    output logic        row_last,
    output logic [31:0] row_gind,
    output logic [31:0] row_cind,
    output logic [63:0] row_data,
    output logic [31:0] issued_cnt,
    output logic        done
);
    localparam int CW = $clog2(SSIZE);
    localparam int DW = $clog2(DEFER_DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SSIZE - 1);

    typedef struct packed {
        logic        vld;
        logic [31:0] iu;
        logic [31:0] iv;
    } pos_t;

    typedef struct packed {
        logic [31:0] iu;
        logic [31:0] iv;
        logic [31:0] off;
        logic [63:0] dat;
    } smp_t;

    logic [CW-1:0]          cnt_q, cnt_d;
    pos_t [HAZ_SLOTS-1:0]   hist_q, hist_d;
    smp_t [DEFER_DEPTH-1:0] def_q, def_d;
    logic [DW-1:0]          def_cnt_q, def_cnt_d;
    logic                   row_valid_q, row_valid_d;
    logic                   row_first_q, row_first_d;
    logic                   row_last_q, row_last_d;
    logic [31:0]            row_gind_q, row_gind_d;
    logic [31:0]            row_cind_q, row_cind_d;
    logic [63:0]            row_data_q, row_data_d;
    logic [31:0]            issued_q, issued_d;
    logic                   slot_last_q, slot_last_d;
    logic                   drain_run_q, drain_run_d;
    logic [31:0]            drain_cnt_q, drain_cnt_d;
    logic                   done_q, done_d;

    logic dec, head_hit, in_hit, at_cap, def_full;
    logic take_head, take_in, push_in, issue;
    smp_t in_smp, sel;

    // Signed 32-bit distance strictly inside the kernel support.
    function automatic logic near(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] d;
        d = a - b;
        return (d > -SSIZE) && (d < SSIZE);
    endfunction

    function automatic logic overlaps(input pos_t h, input logic [31:0] iu, input logic [31:0] iv);
        return h.vld && near(iu, h.iu) && near(iv, h.iv);
    endfunction

    always_comb begin
        in_smp   = '{iu: in_iu, iv: in_iv, off: in_offset, dat: in_data};
        dec      = (cnt_q == CNT_LAST);
        head_hit = 1'b0;
        in_hit   = 1'b0;
        for (int i = 0; i < HAZ_SLOTS; i++) begin
            head_hit = head_hit | overlaps(hist_q[i], def_q[0].iu, def_q[0].iv);
            in_hit   = in_hit | overlaps(hist_q[i], in_iu, in_iv);
        end
        at_cap    = (issued_q + 32'(def_cnt_q)) == 32'(NSAMPLE);
        def_full  = (def_cnt_q == DW'(DEFER_DEPTH));
        take_head = dec && (def_cnt_q != '0) && !head_hit;
        take_in   = dec && !take_head && in_valid && !at_cap && !in_hit;
        push_in   = dec && !take_head && in_valid && !at_cap && in_hit && !def_full;
        issue     = take_head || take_in;
        sel       = take_head ? def_q[0] : in_smp;

        cnt_d       = dec ? '0 : cnt_q + 1'b1;
        hist_d      = hist_q;
        def_d       = def_q;
        def_cnt_d   = def_cnt_q;
        row_valid_d = row_valid_q;
        row_gind_d  = row_gind_q;
        row_cind_d  = row_cind_q;
        row_data_d  = row_data_q;
        slot_last_d = slot_last_q;
        issued_d    = issued_q;
        drain_run_d = drain_run_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = done_q;

        if (take_head) begin
            for (int i = 0; i < DEFER_DEPTH - 1; i++) def_d[i] = def_q[i+1];
            def_d[DEFER_DEPTH-1] = '0;
            def_cnt_d = def_cnt_q - 1'b1;
        end
        if (push_in) begin
            for (int i = 0; i < DEFER_DEPTH; i++) begin
                if (def_cnt_q == DW'(i)) def_d[i] = in_smp;
            end
            def_cnt_d = def_cnt_q + 1'b1;
        end

        if (dec) begin
            for (int i = HAZ_SLOTS - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
            hist_d[0]   = '{vld: issue, iu: sel.iu, iv: sel.iv};
            row_valid_d = issue;
            row_gind_d  = issue ? sel.iu + sel.iv * 32'(GSIZE) - 32'(SUPPORT) : '0;
            row_cind_d  = issue ? sel.off : '0;
            row_data_d  = issue ? sel.dat : '0;
            slot_last_d = issue && (issued_q + 32'd1 == 32'(NSAMPLE));
            if (issue && issued_q != 32'(NSAMPLE)) issued_d = issued_q + 32'd1;
        end else if (row_valid_q) begin
            row_gind_d = row_gind_q + 32'(GSIZE);
            row_cind_d = row_cind_q + 32'(SSIZE);
        end
        row_first_d = (cnt_d == '0);
        row_last_d  = (cnt_d == CNT_LAST);

        // Drain is counted from the cycle the final sample's last row is on the bus.
        if (row_last_q && slot_last_q) begin
            drain_cnt_d = 32'd1;
            if (DRAIN <= 1) done_d = 1'b1;
            else drain_run_d = 1'b1;
        end else if (drain_run_q) begin
            drain_cnt_d = drain_cnt_q + 32'd1;
            if (drain_cnt_d == 32'(DRAIN)) begin
                done_d      = 1'b1;
                drain_run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= CNT_LAST;
            hist_q      <= '0;
            def_q       <= '0;
            def_cnt_q   <= '0;
            row_valid_q <= 1'b0;
            row_first_q <= 1'b0;
            row_last_q  <= 1'b0;
            row_gind_q  <= '0;
            row_cind_q  <= '0;
            row_data_q  <= '0;
            issued_q    <= '0;
            slot_last_q <= 1'b0;
            drain_run_q <= 1'b0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hist_q      <= hist_d;
            def_q       <= def_d;
            def_cnt_q   <= def_cnt_d;
            row_valid_q <= row_valid_d;
            row_first_q <= row_first_d;
            row_last_q  <= row_last_d;
            row_gind_q  <= row_gind_d;
            row_cind_q  <= row_cind_d;
            row_data_q  <= row_data_d;
            issued_q    <= issued_d;
            slot_last_q <= slot_last_d;
            drain_run_q <= drain_run_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    assign in_ready   = take_in || push_in;
    assign row_valid  = row_valid_q;
    assign row_first  = row_first_q;
    assign row_last   = row_last_q;
    assign row_gind   = row_gind_q;
    assign row_cind   = row_cind_q;
    assign row_data   = row_data_q;
    assign issued_cnt = issued_q;
    assign done       = done_q;
endmodule

// File: tb/tb_gridding_sched.sv
// Bench for gridding_sched: slot-level reference model with queues, fixed vectors and directed corner sequences.
module tb_gridding_sched;
    localparam int SSIZE   = 15;
    localparam int GSIZE   = 128;
    localparam int SUPPORT = 7;
    localparam int DRAIN   = 8;
    localparam int NS_MAIN = 1820;
    localparam logic [31:0] BUB = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid;
    logic [31:0] in_iu, in_iv, in_offset;
    logic [63:0] in_data;

    logic        a_in_ready, a_row_valid, a_row_first, a_row_last, a_done;
    logic [31:0] a_row_gind, a_row_cind, a_issued;
    logic [63:0] a_row_data;
    logic        b_in_ready, b_row_valid, b_row_first, b_row_last, b_done;
    logic [31:0] b_row_gind, b_row_cind, b_issued;
    logic [63:0] b_row_data;

    gridding_sched u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_iu(in_iu), .in_iv(in_iv), .in_offset(in_offset), .in_data(in_data),
        .row_valid(a_row_valid), .row_first(a_row_first), .row_last(a_row_last),
        .row_gind(a_row_gind), .row_cind(a_row_cind), .row_data(a_row_data),
        .issued_cnt(a_issued), .done(a_done)
    );

    gridding_sched #(.NSAMPLE(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_iu(in_iu), .in_iv(in_iv), .in_offset(in_offset), .in_data(in_data),
        .row_valid(b_row_valid), .row_first(b_row_first), .row_last(b_row_last),
        .row_gind(b_row_gind), .row_cind(b_row_cind), .row_data(b_row_data),
        .issued_cnt(b_issued), .done(b_done)
    );

    bit sel3 = 1'b0;
    logic        o_in_ready, o_row_valid, o_row_first, o_row_last, o_done;
    logic [31:0] o_row_gind, o_row_cind, o_issued;
    logic [63:0] o_row_data;
    assign o_in_ready  = sel3 ? b_in_ready  : a_in_ready;
    assign o_row_valid = sel3 ? b_row_valid : a_row_valid;
    assign o_row_first = sel3 ? b_row_first : a_row_first;
    assign o_row_last  = sel3 ? b_row_last  : a_row_last;
    assign o_row_gind  = sel3 ? b_row_gind  : a_row_gind;
    assign o_row_cind  = sel3 ? b_row_cind  : a_row_cind;
    assign o_row_data  = sel3 ? b_row_data  : a_row_data;
    assign o_issued    = sel3 ? b_issued    : a_issued;
    assign o_done      = sel3 ? b_done      : a_done;

    typedef struct packed {
        logic        vld;
        logic [31:0] iu;
        logic [31:0] iv;
        logic [31:0] off;
        logic [63:0] dat;
    } smp_t;

    typedef struct {
        logic [31:0] iu, iv, off;
        logic [31:0] g0, g14, c14;
    } vec_t;

    int total = 0;
    int bad   = 0;

    smp_t src[$];
    smp_t m_defer[$];
    smp_t m_h0, m_h1, m_slot;
    int   m_issued, m_ns, m_ph, m_cyc, m_tlast;
    bit   m_slot_last;
    bit   rnd_gap;

    logic [31:0] obs_order[$];
    bit          obs_rdy[$];
    logic [31:0] obs_g0, obs_g14, obs_c14;
    int          obs_done_cyc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, m_cyc);
        end
    endtask

    function automatic smp_t mk(input logic [31:0] iu, input logic [31:0] iv, input logic [31:0] off);
        smp_t s;
        s.vld = 1'b1; s.iu = iu; s.iv = iv; s.off = off;
        s.dat = {$urandom, $urandom};
        return s;
    endfunction

    function automatic bit conflict(input smp_t a, input smp_t b);
        int du, dv;
        if (!(a.vld && b.vld)) return 1'b0;
        du = int'(a.iu - b.iu);
        dv = int'(a.iv - b.iv);
        if (du < 0) du = -du;
        if (dv < 0) dv = -dv;
        return (du < SSIZE) && (dv < SSIZE);
    endfunction

    function automatic logic [31:0] gind_of(input smp_t s);
        return s.iu + s.iv * GSIZE - SUPPORT;
    endfunction

    // One slot decision following the priority list, on queues.
    task automatic model_decide(input bit pv, input smp_t p, output bit rdy, output smp_t nxt);
        bit cap;
        nxt = '0;
        rdy = 1'b0;
        cap = (m_issued + m_defer.size()) == m_ns;
        if (m_defer.size() > 0 && !conflict(m_defer[0], m_h0) && !conflict(m_defer[0], m_h1)) begin
            nxt = m_defer.pop_front();
        end else if (pv && !cap) begin
            if (!conflict(p, m_h0) && !conflict(p, m_h1)) begin
                nxt = p;
                rdy = 1'b1;
            end else if (m_defer.size() < 2) begin
                m_defer.push_back(p);
                rdy = 1'b1;
            end
        end
        m_h1 = m_h0;
        m_h0 = nxt;
        if (nxt.vld) m_issued++;
    endtask

    task automatic cycle();
        smp_t cur, nxt;
        bit rdy, dec, pres;
        logic [31:0] eg, ec;
        pres = (src.size() > 0) && !(rnd_gap && $urandom_range(0, 3) == 0);
        cur = pres ? src[0] : '0;
        in_valid  = pres;
        in_iu     = cur.iu;
        in_iv     = cur.iv;
        in_offset = cur.off;
        in_data   = cur.dat;
        #1;
        dec = (m_ph == SSIZE - 1);
        rdy = 1'b0;
        nxt = '0;
        if (dec) model_decide(pres, cur, rdy, nxt);
        chk("in_ready", o_in_ready, rdy);
        if (dec) obs_rdy.push_back(o_in_ready);
        if (pres && rdy) void'(src.pop_front());
        @(posedge clk);
        #1;
        m_cyc++;
        if (dec) begin
            m_ph = 0;
            m_slot = nxt;
            m_slot_last = nxt.vld && (m_issued == m_ns);
        end else begin
            m_ph++;
        end
        eg = m_slot.vld ? gind_of(m_slot) + 32'(m_ph * GSIZE) : 32'd0;
        ec = m_slot.vld ? m_slot.off + 32'(m_ph * SSIZE) : 32'd0;
        chk("row_valid", o_row_valid, m_slot.vld);
        chk("row_first", o_row_first, m_ph == 0);
        chk("row_last", o_row_last, m_ph == SSIZE - 1);
        chk("row_gind", o_row_gind, eg);
        chk("row_cind", o_row_cind, ec);
        chk("row_data", o_row_data, m_slot.vld ? m_slot.dat : 64'd0);
        chk("issued_cnt", o_issued, m_issued);
        if (m_ph == SSIZE - 1 && m_slot_last && m_tlast < 0) m_tlast = m_cyc;
        chk("done", o_done, m_tlast >= 0 && m_cyc >= m_tlast + DRAIN);
        if (m_ph == 0) obs_order.push_back(o_row_valid ? o_row_gind : BUB);
        if (m_ph == 0 && o_row_valid) obs_g0 = o_row_gind;
        if (m_ph == SSIZE - 1 && o_row_valid) begin
            obs_g14 = o_row_gind;
            obs_c14 = o_row_cind;
        end
        if (o_done && obs_done_cyc < 0) obs_done_cyc = m_cyc;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; in_iu = '0; in_iv = '0; in_offset = '0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_row_valid", o_row_valid, 0);
        chk("rst_row_first", o_row_first, 0);
        chk("rst_row_last", o_row_last, 0);
        chk("rst_row_gind", o_row_gind, 0);
        chk("rst_row_data", o_row_data, 0);
        chk("rst_issued", o_issued, 0);
        chk("rst_done", o_done, 0);
        chk("rst_in_ready", o_in_ready, 0);
        src.delete(); m_defer.delete(); obs_order.delete(); obs_rdy.delete();
        m_h0 = '0; m_h1 = '0; m_slot = '0; m_slot_last = 1'b0;
        m_issued = 0; m_ph = SSIZE - 1; m_cyc = 0; m_tlast = -1;
        m_ns = sel3 ? 3 : NS_MAIN;
        obs_g0 = '0; obs_g14 = '0; obs_c14 = '0; obs_done_cyc = -1;
        rst = 1'b1;
    endtask

    task automatic chk_order(input string nm, input int idx, input logic [31:0] exp);
        chk(nm, (idx < obs_order.size()) ? obs_order[idx] : 32'hBAD0_BAD0, exp);
    endtask

    task automatic chk_rdy(input string nm, input int idx, input bit exp);
        chk(nm, (idx < obs_rdy.size()) ? 64'(obs_rdy[idx]) : 64'hBAD, exp);
    endtask

    vec_t vt[5];

    initial begin
        rst = 1'b0;
        rnd_gap = 1'b0;
        m_cyc = 0;
        vt[0] = '{32'd20, 32'd10, 32'd0, 32'd1293, 32'd3085, 32'd210};
        vt[1] = '{32'd7, 32'd0, 32'd100, 32'd0, 32'd1792, 32'd310};
        vt[2] = '{32'd1000, 32'd3, 32'd5, 32'd1377, 32'd3169, 32'd215};
        vt[3] = '{32'd7, 32'h01FF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FF80, 32'h0000_0680, 32'h0000_00C2};
        vt[4] = '{32'hFFFF_FFFF, 32'd0, 32'd3, 32'hFFFF_FFF8, 32'h0000_06F8, 32'd213};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            src.push_back(mk(vt[i].iu, vt[i].iv, vt[i].off));
            run_cycles(SSIZE);
            chk($sformatf("vec%0d_gind_row0", i), obs_g0, vt[i].g0);
            chk($sformatf("vec%0d_gind_row14", i), obs_g14, vt[i].g14);
            chk($sformatf("vec%0d_cind_row14", i), obs_c14, vt[i].c14);
            chk($sformatf("vec%0d_issued", i), o_issued, 1);
        end

        // Back-to-back non-conflicting samples: no bubble between them.
        do_reset();
        src.push_back(mk(20, 10, 0));
        src.push_back(mk(60, 10, 0));
        run_cycles(3 * SSIZE);
        chk_order("b2b_slot0", 0, 32'd1293);
        chk_order("b2b_slot1", 1, 32'd1333);

        // B overlaps A and is deferred; C passes it.
        do_reset();
        src.push_back(mk(20, 10, 0));
        src.push_back(mk(25, 12, 0));
        src.push_back(mk(60, 10, 0));
        run_cycles(5 * SSIZE);
        chk_order("reo_slot0", 0, 32'd1293);
        chk_order("reo_slot1", 1, BUB);
        chk_order("reo_slot2", 2, 32'd1333);
        chk_order("reo_slot3", 3, 32'd1554);
        chk("reo_issued", o_issued, 3);

        // Defer buffer fills; third overlapping input waits for the pop.
        do_reset();
        src.push_back(mk(20, 10, 0));
        src.push_back(mk(21, 10, 0));
        src.push_back(mk(22, 10, 0));
        src.push_back(mk(23, 10, 0));
        run_cycles(11 * SSIZE);
        chk_rdy("df_rdy0", 0, 1);
        chk_rdy("df_rdy1", 1, 1);
        chk_rdy("df_rdy2", 2, 1);
        chk_rdy("df_rdy3", 3, 0);
        chk_rdy("df_rdy4", 4, 1);
        chk_order("df_slot3", 3, 32'd1294);
        chk_order("df_slot6", 6, 32'd1295);
        chk_order("df_slot9", 9, 32'd1296);
        chk("df_issued", o_issued, 4);

        // Completion on the NSAMPLE=3 instance; a fourth sample must be refused.
        sel3 = 1'b1;
        do_reset();
        src.push_back(mk(20, 10, 0));
        src.push_back(mk(60, 10, 0));
        src.push_back(mk(100, 10, 0));
        src.push_back(mk(140, 10, 0));
        run_cycles(6 * SSIZE);
        chk("cmp_issued", o_issued, 3);
        chk("cmp_done_cycle", obs_done_cyc, 53);
        chk_order("cmp_slot2", 2, 32'd1373);
        chk_order("cmp_slot3", 3, BUB);
        chk_order("cmp_slot5", 5, BUB);
        sel3 = 1'b0;

        // Asynchronous reset in the middle of a valid slot.
        do_reset();
        src.push_back(mk(20, 10, 0));
        run_cycles(8);
        chk("arst_pre_valid", o_row_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("arst_row_valid", o_row_valid, 0);
        chk("arst_issued", o_issued, 0);
        chk("arst_row_gind", o_row_gind, 0);
        do_reset();
        src.push_back(mk(60, 10, 0));
        run_cycles(1);
        chk("arst_first_valid", o_row_valid, 1);
        chk("arst_first_gind", o_row_gind, 32'd1333);
        chk("arst_first_flag", o_row_first, 1);

        // Randomized traffic in a small window so overlaps are frequent.
        do_reset();
        rnd_gap = 1'b1;
        for (int i = 0; i < 200; i++)
            src.push_back(mk($urandom_range(7, 70), $urandom_range(0, 40), $urandom));
        begin
            int guard = 0;
            while ((src.size() > 0 || m_defer.size() > 0) && guard < 3000) begin
                run_cycles(SSIZE);
                guard++;
            end
            if (guard >= 3000) begin
                total++;
                bad++;
                $display("FAIL rand_drain: %0d samples still pending after budget", src.size() + m_defer.size());
            end
        end
        rnd_gap = 1'b0;
        run_cycles(2 * SSIZE);
        chk("rand_issued", o_issued, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
